// File: rtl/ctrl_link_slave_framer.sv
// ctrl_link_slave_framer: byte-level control-link slave on byte_clk.
// Deframes comma-led request frames into a strobe/ack register-bus
// transaction, with tag de-duplication and an ack timeout, and streams
// status/readback frames back continuously.
// Build macro CTRL_LINK_CHECKSUM_EN: inbound and outbound frames carry a
// trailing XOR checksum byte; a bad inbound checksum discards the frame.
module ctrl_link_slave_framer #(
    parameter int ADDR_BYTES     = 2,
    parameter int DATA_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    byte_clk,
    input  logic                    reset,
    input  logic                    link_ok,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_k,
    output logic [7:0]              tx_byte,
    output logic                    tx_k,
    output logic [8*ADDR_BYTES-1:0] address,
    output logic [8*DATA_BYTES-1:0] data_out,
    output logic                    request_is_write,
    output logic                    strobe,
    input  logic                    ack,
    input  logic [8*DATA_BYTES-1:0] data_in,
    output logic [7:0]              frame_err_count
);
`ifdef CTRL_LINK_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    // bytes stored after the comma, and outbound frame length
    localparam int RX_BYTES = 1 + ADDR_BYTES + DATA_BYTES + CK;
    localparam int TX_LEN   = 2 + DATA_BYTES + CK;
    localparam int IDX_W    = $clog2(RX_BYTES + 1);
    localparam int PTR_W    = $clog2(TX_LEN + 1);
    localparam int TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] COMMA = 8'h3C;

    typedef enum logic [1:0] {HUNT, COLLECT, COMMIT} rx_state_t;

    rx_state_t                 state, state_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    logic                      store, frame_err;
    logic [RX_BYTES-1:0][7:0]  rx_buf;
    logic [7:0]                rx_flags;
    logic [8*ADDR_BYTES-1:0]   rx_addr;
    logic [8*DATA_BYTES-1:0]   rx_data;
    logic                      ck_bad, accept;
    logic [1:0]                unused_flags;

    logic [3:0]                last_tag;
    logic                      tag_valid, done, err, busy;
    logic [TMR_W-1:0]          timer;
    logic [8*DATA_BYTES-1:0]   rd_data;

    logic [PTR_W-1:0]          tx_ptr;
    logic [7:0]                snap_status, tx_data_sel;
    logic [DATA_BYTES-1:0][7:0] snap_data;

    assign rx_flags     = rx_buf[0];
    assign rx_addr      = rx_buf[ADDR_BYTES:1];
    assign rx_data      = rx_buf[ADDR_BYTES+DATA_BYTES:ADDR_BYTES+1];
    assign unused_flags = rx_flags[3:2];

`ifdef CTRL_LINK_CHECKSUM_EN
    logic [7:0] rx_ck, tx_ck;
    // XOR over payload plus checksum byte is zero for a good frame
    always_comb begin
        rx_ck = 8'h00;
        for (int i = 0; i < RX_BYTES; i++) rx_ck ^= rx_buf[i];
    end
    assign ck_bad = (rx_ck != 8'h00);
    // outbound checksum over the snapshotted status and data bytes
    always_comb begin
        tx_ck = snap_status;
        for (int i = 0; i < DATA_BYTES; i++) tx_ck ^= snap_data[i];
    end
`else
    assign ck_bad = 1'b0;
`endif

    // a busy slave or a repeated tag drops the frame silently
    assign accept = (state == COMMIT) && !ck_bad && rx_flags[0] && !strobe &&
                    (!tag_valid || (rx_flags[7:4] != last_tag));

    // rx framer state register and payload capture
    always_ff @(posedge byte_clk) begin
        if (reset) begin
            state  <= HUNT;
            idx    <= '0;
            rx_buf <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            for (int i = 0; i < RX_BYTES; i++)
                if (store && (idx == IDX_W'(i))) rx_buf[i] <= rx_byte;
        end
    end

    // rx framer next state; comma mid-frame restarts, other K aborts
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        store     = 1'b0;
        frame_err = 1'b0;
        case (state)
            HUNT: begin
                if (link_ok && rx_k && (rx_byte == COMMA)) begin
                    state_nxt = COLLECT;
                    idx_nxt   = '0;
                end
            end
            COLLECT: begin
                if (!link_ok) begin
                    state_nxt = HUNT;
                end else if (rx_k && (rx_byte == COMMA)) begin
                    idx_nxt   = '0;
                    frame_err = 1'b1;
                end else if (rx_k) begin
                    state_nxt = HUNT;
                    frame_err = 1'b1;
                end else begin
                    store = 1'b1;
                    if (idx == IDX_W'(RX_BYTES - 1)) state_nxt = COMMIT;
                    else                             idx_nxt   = idx + IDX_W'(1);
                end
            end
            COMMIT: begin
                state_nxt = HUNT;
                frame_err = ck_bad;
            end
            default: state_nxt = HUNT;
        endcase
    end

    // saturating count of discarded inbound frames
    always_ff @(posedge byte_clk) begin
        if (reset)                                  frame_err_count <= 8'h00;
        else if (frame_err && frame_err_count != 8'hFF) frame_err_count <= frame_err_count + 8'h01;
    end

    // bus transaction: launch on accept, end on ack (wins) or timeout
    always_ff @(posedge byte_clk) begin
        if (reset) begin
            address          <= '0;
            data_out         <= '0;
            request_is_write <= 1'b0;
            strobe           <= 1'b0;
            last_tag         <= 4'h0;
            tag_valid        <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            busy             <= 1'b0;
            timer            <= '0;
            rd_data          <= '0;
        end else if (accept) begin
            address          <= rx_addr;
            data_out         <= rx_data;
            request_is_write <= rx_flags[1];
            last_tag         <= rx_flags[7:4];
            tag_valid        <= 1'b1;
            strobe           <= 1'b1;
            busy             <= 1'b1;
            done             <= 1'b0;
            err              <= 1'b0;
            timer            <= '0;
        end else if (strobe) begin
            if (ack) begin
                strobe <= 1'b0;
                done   <= 1'b1;
                busy   <= 1'b0;
                if (!request_is_write) rd_data <= data_in;
            end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                strobe <= 1'b0;
                done   <= 1'b1;
                err    <= 1'b1;
                busy   <= 1'b0;
            end else begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    // pick the readback byte for the current tx pointer
    always_comb begin
        tx_data_sel = 8'h00;
        for (int i = 0; i < DATA_BYTES; i++)
            if (tx_ptr == PTR_W'(i + 2)) tx_data_sel = snap_data[i];
    end

    // outbound stream; status and data frozen when the comma goes out
    always_ff @(posedge byte_clk) begin
        if (reset) begin
            tx_ptr      <= '0;
            tx_byte     <= 8'h00;
            tx_k        <= 1'b0;
            snap_status <= 8'h00;
            snap_data   <= '0;
        end else begin
            tx_ptr <= (tx_ptr == PTR_W'(TX_LEN - 1)) ? '0 : tx_ptr + PTR_W'(1);
            tx_k   <= (tx_ptr == '0);
            if (tx_ptr == '0) begin
                tx_byte     <= COMMA;
                snap_status <= {last_tag, 1'b0, err, busy, done};
                snap_data   <= rd_data;
            end else if (tx_ptr == PTR_W'(1)) begin
                tx_byte <= snap_status;
`ifdef CTRL_LINK_CHECKSUM_EN
            end else if (tx_ptr == PTR_W'(TX_LEN - 1)) begin
                tx_byte <= tx_ck;
`endif
            end else begin
                tx_byte <= tx_data_sel;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_link_slave_framer.sv
// tb_ctrl_link_slave_framer: directed self-checking bench for
// ctrl_link_slave_framer (ADDR_BYTES=2, DATA_BYTES=4, TIMEOUT_CYCLES=255).
// Honours CTRL_LINK_CHECKSUM_EN when defined.
module tb_ctrl_link_slave_framer;
`ifdef CTRL_LINK_CHECKSUM_EN
    localparam int CKB = 1;
`else
    localparam int CKB = 0;
`endif
    localparam int TX_M = 6 + CKB;

    logic        byte_clk = 1'b0;
    logic        reset    = 1'b1;
    logic        link_ok  = 1'b1;
    logic [7:0]  rx_byte  = 8'h00;
    logic        rx_k     = 1'b0;
    logic        ack      = 1'b0;
    logic [31:0] data_in  = 32'h0;
    logic [7:0]  tx_byte;
    logic        tx_k;
    logic [15:0] address;
    logic [31:0] data_out;
    logic        request_is_write;
    logic        strobe;
    logic [7:0]  frame_err_count;

    int n_chk  = 0;
    int n_fail = 0;

    ctrl_link_slave_framer #(.ADDR_BYTES(2), .DATA_BYTES(4), .TIMEOUT_CYCLES(255)) dut (
        .byte_clk(byte_clk), .reset(reset), .link_ok(link_ok),
        .rx_byte(rx_byte), .rx_k(rx_k), .tx_byte(tx_byte), .tx_k(tx_k),
        .address(address), .data_out(data_out), .request_is_write(request_is_write),
        .strobe(strobe), .ack(ack), .data_in(data_in), .frame_err_count(frame_err_count)
    );

    always #5 byte_clk = ~byte_clk;

    // monitor: strobe statistics and outbound frame capture
    int         strobe_hi = 0, rise = 0, k_bad = 0, frame_cnt = 0, gap = 0, pos = TX_M;
    bit         seen_k = 1'b0, strobe_q = 1'b0;
    logic [7:0] cur [0:7];
    logic [7:0] last_frame [0:7];

    always @(negedge byte_clk) begin
        if (strobe) strobe_hi++;
        if (strobe && !strobe_q) rise++;
        strobe_q = strobe;
        if (reset) begin
            seen_k = 1'b0;
            pos    = TX_M;
        end else if (tx_k) begin
            if (seen_k && gap != TX_M) k_bad++;
            if (tx_byte != 8'h3C) k_bad++;
            seen_k = 1'b1;
            gap    = 1;
            cur[0] = tx_byte;
            pos    = 1;
        end else begin
            gap++;
            if (seen_k && gap > TX_M) k_bad++;
            if (pos < TX_M) begin
                cur[pos] = tx_byte;
                pos++;
                if (pos == TX_M) begin
                    last_frame = cur;
                    frame_cnt++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge byte_clk);
        #1;
    endtask

    task automatic put(input logic k, input logic [7:0] b);
        rx_k    = k;
        rx_byte = b;
        tick();
    endtask

    // comma, flags, addr LSB first, data LSB first, optional checksum
    task automatic send_frame(input logic [7:0] flags, input logic [15:0] addr,
                              input logic [31:0] data, input bit corrupt);
        logic [7:0] b [0:6];
        logic [7:0] ck;
        b[0] = flags;
        b[1] = addr[7:0];   b[2] = addr[15:8];
        b[3] = data[7:0];   b[4] = data[15:8];
        b[5] = data[23:16]; b[6] = data[31:24];
        ck = 8'h00;
        for (int i = 0; i < 7; i++) ck ^= b[i];
        if (corrupt) ck ^= 8'h01;
        put(1'b1, 8'h3C);
        for (int i = 0; i < 7; i++) put(1'b0, b[i]);
        if (CKB != 0) put(1'b0, ck);
        rx_k    = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic wait_frames(input int n);
        int start = frame_cnt;
        int t = 0;
        while (frame_cnt < start + n && t < 20 * TX_M * n) begin
            tick();
            t++;
        end
        chk("frame_wait", 64'(frame_cnt - start >= n), 64'd1);
    endtask

    task automatic pulse_ack(input logic [31:0] d);
        ack     = 1'b1;
        data_in = d;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_tx_byte", 64'(tx_byte), 64'h0);
        chk("rst_tx_k", 64'(tx_k), 64'h0);
        chk("rst_strobe", 64'(strobe), 64'h0);
        chk("rst_address", 64'(address), 64'h0);
        chk("rst_data_out", 64'(data_out), 64'h0);
        chk("rst_rw", 64'(request_is_write), 64'h0);
        chk("rst_err_cnt", 64'(frame_err_count), 64'h0);
        reset = 1'b0;
        tick();
        chk("rst_first_comma", 64'({tx_k, tx_byte}), 64'h13C);
        repeat (4) tick();

        // 1: read, tag 1, addr 0x1234, ack 3 cycles after strobe
        strobe_hi = 0;
        send_frame(8'h11, 16'h1234, 32'h0, 1'b0);
        chk("t1_lat_early", 64'(strobe), 64'h0);
        tick();
        chk("t1_lat_strobe", 64'(strobe), 64'h1);
        chk("t1_address", 64'(address), 64'h1234);
        chk("t1_rw", 64'(request_is_write), 64'h0);
        repeat (3) tick();
        pulse_ack(32'hCAFEBABE);
        chk("t1_strobe_drop", 64'(strobe), 64'h0);
        tick();
        chk("t1_strobe_len", 64'(strobe_hi), 64'd4);
        wait_frames(2);
        chk("t1_status", 64'(last_frame[1]), 64'h11);
        chk("t1_rd_bytes", 64'({last_frame[2], last_frame[3], last_frame[4], last_frame[5]}), 64'hBEBAFECA);
`ifdef CTRL_LINK_CHECKSUM_EN
        chk("t1_tx_ck", 64'(last_frame[6]), 64'h21);
`endif

        // 2: same write frame five times back to back, ack held high
        rise = 0; strobe_hi = 0;
        ack = 1'b1;
        for (int r = 0; r < 5; r++) send_frame(8'h23, 16'h0055, 32'h3C3C3C3C, 1'b0);
        repeat (4) tick();
        ack = 1'b0;
        chk("t2_one_strobe", 64'(rise), 64'd1);
        chk("t2_strobe_len", 64'(strobe_hi), 64'd1);
        chk("t2_address", 64'(address), 64'h0055);
        chk("t2_data_out", 64'(data_out), 64'h3C3C3C3C);
        chk("t2_rw", 64'(request_is_write), 64'h1);
        wait_frames(2);
        chk("t2_status", 64'(last_frame[1]), 64'h21);
        chk("t2_rd_held", 64'({last_frame[2], last_frame[5]}), 64'hBECA);
        chk("t2_tx_k", 64'(k_bad), 64'd0);

        // 3: read with no ack times out; link_ok drop does not cancel
        strobe_hi = 0;
        send_frame(8'h31, 16'h0100, 32'h0, 1'b0);
        tick();
        chk("t3_strobe", 64'(strobe), 64'h1);
        for (int t = 0; t < 400 && strobe; t++) begin
            link_ok = !(t >= 10 && t < 20);
            tick();
        end
        link_ok = 1'b1;
        chk("t3_timeout_len", 64'(strobe_hi), 64'd255);
        wait_frames(2);
        chk("t3_status", 64'(last_frame[1]), 64'h35);
        send_frame(8'h41, 16'h0200, 32'h0, 1'b0);
        tick();
        chk("t3_new_tag", 64'(strobe), 64'h1);
        chk("t3_new_addr", 64'(address), 64'h0200);
        pulse_ack(32'h3C3C3C3C);
        wait_frames(2);
        chk("t3_status2", 64'(last_frame[1]), 64'h41);
        chk("t3_rd_3c", 64'({last_frame[2], last_frame[3], last_frame[4], last_frame[5]}), 64'h3C3C3C3C);
        chk("t3_tx_k", 64'(k_bad), 64'd0);

        // 4: comma after 3 payload bytes, then a full valid frame
        put(1'b1, 8'h3C); put(1'b0, 8'h53); put(1'b0, 8'hEF); put(1'b0, 8'hBE);
        send_frame(8'h53, 16'hBEEF, 32'h12345678, 1'b0);
        chk("t4_err_cnt", 64'(frame_err_count), 64'd1);
        chk("t4_lat_early", 64'(strobe), 64'h0);
        tick();
        chk("t4_strobe", 64'(strobe), 64'h1);
        chk("t4_address", 64'(address), 64'hBEEF);
        chk("t4_data_out", 64'(data_out), 64'h12345678);
        chk("t4_rw", 64'(request_is_write), 64'h1);
        pulse_ack(32'h0);

        // other K mid-frame counts; link loss does not; FLAGS[0]=0 is silent
        rise = 0;
        put(1'b1, 8'h3C); put(1'b0, 8'h63); put(1'b1, 8'hBC);
        rx_k = 1'b0; rx_byte = 8'h00;
        tick();
        chk("k_abort_err", 64'(frame_err_count), 64'd2);
        put(1'b1, 8'h3C); put(1'b0, 8'h63);
        link_ok = 1'b0;
        put(1'b0, 8'h11);
        link_ok = 1'b1;
        for (int i = 0; i < 6; i++) put(1'b0, 8'h00);
        send_frame(8'h60, 16'h0600, 32'h0, 1'b0);
        repeat (3) tick();
        chk("noreq_strobe", 64'(rise), 64'd0);
        chk("noreq_err", 64'(frame_err_count), 64'd2);

        // saturation: a held comma restarts collection every cycle
        rx_k = 1'b1; rx_byte = 8'h3C;
        repeat (300) tick();
        rx_k = 1'b0; rx_byte = 8'h00;
        repeat (12) tick();
        chk("err_saturate", 64'(frame_err_count), 64'hFF);

        // 5: reset while strobe high; the same tag is accepted afterwards
        send_frame(8'h71, 16'h0777, 32'h0, 1'b0);
        tick();
        chk("t5_strobe", 64'(strobe), 64'h1);
        reset = 1'b1;
        tick();
        chk("t5_rst_strobe", 64'(strobe), 64'h0);
        chk("t5_rst_addr", 64'(address), 64'h0);
        chk("t5_rst_tx", 64'({tx_k, tx_byte}), 64'h0);
        chk("t5_rst_err", 64'(frame_err_count), 64'h0);
        reset = 1'b0;
        tick();
        chk("t5_tx_restart", 64'({tx_k, tx_byte}), 64'h13C);
        send_frame(8'h71, 16'h0777, 32'h0, 1'b0);
        tick();
        chk("t5_retag", 64'(strobe), 64'h1);
        chk("t5_address", 64'(address), 64'h0777);
        pulse_ack(32'h0);

`ifdef CTRL_LINK_CHECKSUM_EN
        // 6: corrupted checksum discarded and counted, good one commits
        rise = 0;
        send_frame(8'h81, 16'h0888, 32'hA5A5A5A5, 1'b1);
        repeat (3) tick();
        chk("t6_bad_ck_strobe", 64'(rise), 64'd0);
        chk("t6_bad_ck_err", 64'(frame_err_count), 64'd1);
        send_frame(8'h81, 16'h0888, 32'hA5A5A5A5, 1'b0);
        tick();
        chk("t6_good_ck", 64'(strobe), 64'h1);
        chk("t6_data_out", 64'(data_out), 64'hA5A5A5A5);
        pulse_ack(32'h0);
`endif

        repeat (2 * TX_M) tick();
        chk("tx_k_final", 64'(k_bad), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
